// File: rtl/rv64_csr_pkg.sv
// ============================================================================
// Module      : rv64_csr_pkg
// Description : Shared CSR addresses, op encoding and field indices for the
//               rv64 machine-mode CSR/trap unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv64_csr_pkg;

    localparam logic [11:0] c_addr_mstatus   = 12'h300;
    localparam logic [11:0] c_addr_misa      = 12'h301;
    localparam logic [11:0] c_addr_mie       = 12'h304;
    localparam logic [11:0] c_addr_mtvec     = 12'h305;
    localparam logic [11:0] c_addr_mscratch  = 12'h340;
    localparam logic [11:0] c_addr_mepc      = 12'h341;
    localparam logic [11:0] c_addr_mcause    = 12'h342;
    localparam logic [11:0] c_addr_mtval     = 12'h343;
    localparam logic [11:0] c_addr_mip       = 12'h344;
    localparam logic [11:0] c_addr_mcycle    = 12'hB00;
    localparam logic [11:0] c_addr_minstret  = 12'hB02;
    localparam logic [11:0] c_addr_mvendorid = 12'hF11;
    localparam logic [11:0] c_addr_marchid   = 12'hF12;
    localparam logic [11:0] c_addr_mimpid    = 12'hF13;
    localparam logic [11:0] c_addr_mhartid   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int c_mstatus_mie    = 3;
    localparam int c_mstatus_mpie   = 7;
    localparam int c_mstatus_mpp_lo = 11;
    localparam int c_mstatus_mpp_hi = 12;
    localparam int c_mie_mtie       = 7;
    localparam int c_mip_mtip       = 7;

    localparam logic [63:0] c_cause_mti = 64'h8000000000000007;

endpackage

`default_nettype wire

// File: rtl/rv64_csr_counter.sv
// ============================================================================
// Module      : rv64_csr_counter
// Description : XLEN-wide free-running counter; a load in the same cycle
//               takes precedence over the increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv64_csr_counter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_data,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_count
);

    logic [XLEN-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_data;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/rv64_csr_trap_unit.sv
// ============================================================================
// Module      : rv64_csr_trap_unit
// Description : Machine-mode CSR file with one-cycle trap entry / mret and
//               vectored redirect. Define CSR_COUNTERS_EN for mcycle/minstret.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv64_csr_trap_unit #(
    parameter int              XLEN          = 64,
    parameter logic [XLEN-1:0] MSTATUS_RESET = 64'h0000000a00001800,
    parameter logic [XLEN-1:0] MTVEC_RESET   = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_illegal_o,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic            mtip_i,
    output logic            irq_pending_o,
    output logic [XLEN-1:0] trap_target_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mstatus_o
);

    import rv64_csr_pkg::*;

    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mie_csr;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_mcycle;
    logic [XLEN-1:0] w_minstret;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_new;
    logic [XLEN-1:0] w_base;
    logic            w_impl;
    logic            w_ro;
    logic            w_write;
    logic            w_illegal;
    logic            w_commit;
    csr_op_e         w_op;

    assign w_op = csr_op_e'(csr_op_i);

    // Only MIE/MPIE are state; everything else is the reset image with MPP pinned to M.
    always_comb begin
        w_mstatus                                    = MSTATUS_RESET;
        w_mstatus[c_mstatus_mie]                     = r_mie;
        w_mstatus[c_mstatus_mpie]                    = r_mpie;
        w_mstatus[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = 2'b11;
    end

    always_comb begin
        w_mip             = '0;
        w_mip[c_mip_mtip] = mtip_i;
    end

    always_comb begin
        w_impl = 1'b1;
        w_ro   = 1'b0;
        w_old  = '0;
        case (csr_addr_i)
            c_addr_mstatus:  w_old = w_mstatus;
            c_addr_mie:      w_old = r_mie_csr;
            c_addr_mtvec:    w_old = r_mtvec;
            c_addr_mscratch: w_old = r_mscratch;
            c_addr_mepc:     w_old = r_mepc;
            c_addr_mcause:   w_old = r_mcause;
            c_addr_mtval:    w_old = r_mtval;
            c_addr_mip:      w_old = w_mip;
            c_addr_mcycle:   w_old = w_mcycle;
            c_addr_minstret: w_old = w_minstret;
            c_addr_misa, c_addr_mvendorid, c_addr_marchid,
            c_addr_mimpid, c_addr_mhartid: w_ro = 1'b1;
            default:         w_impl = 1'b0;
        endcase
    end

    always_comb begin
        case (w_op)
            CSR_OP_RW: w_new = csr_wdata_i;
            CSR_OP_RS: w_new = w_old | csr_wdata_i;
            CSR_OP_RC: w_new = w_old & ~csr_wdata_i;
            default:   w_new = w_old;
        endcase
    end

    // RS/RC with a zero operand is a pure read, so it may target RO CSRs.
    assign w_write   = (w_op == CSR_OP_RW) ||
                       (((w_op == CSR_OP_RS) || (w_op == CSR_OP_RC)) && (|csr_wdata_i));
    assign w_illegal = (w_op != CSR_OP_NONE) &&
                       (!w_impl || (w_write && (w_ro || (csr_addr_i == c_addr_mip))));
    assign w_commit  = w_write && !w_illegal && !trap_valid_i && !mret_i;

    assign csr_rdata_o   = w_illegal ? '0 : w_old;
    assign csr_illegal_o = w_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie      <= MSTATUS_RESET[c_mstatus_mie];
            r_mpie     <= MSTATUS_RESET[c_mstatus_mpie];
            r_mie_csr  <= '0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (trap_valid_i) begin
            r_mepc   <= {trap_pc_i[XLEN-1:1], 1'b0};
            r_mcause <= trap_cause_i;
            r_mtval  <= trap_tval_i;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (mret_i) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_commit) begin
            case (csr_addr_i)
                c_addr_mstatus: begin
                    r_mie  <= w_new[c_mstatus_mie];
                    r_mpie <= w_new[c_mstatus_mpie];
                end
                c_addr_mie:      r_mie_csr  <= w_new;
                c_addr_mtvec:    r_mtvec    <= {w_new[XLEN-1:2], w_new[1] ? 2'b00 : w_new[1:0]};
                c_addr_mscratch: r_mscratch <= w_new;
                c_addr_mepc:     r_mepc     <= {w_new[XLEN-1:1], 1'b0};
                c_addr_mcause:   r_mcause   <= w_new;
                c_addr_mtval:    r_mtval    <= w_new;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    rv64_csr_counter #(.XLEN(XLEN)) u_mcycle (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_commit && (csr_addr_i == c_addr_mcycle)),
        .i_load_data (w_new),
        .i_inc       (1'b1),
        .o_count     (w_mcycle)
    );

    rv64_csr_counter #(.XLEN(XLEN)) u_minstret (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_commit && (csr_addr_i == c_addr_minstret)),
        .i_load_data (w_new),
        .i_inc       (retire_i),
        .o_count     (w_minstret)
    );
`else
    logic w_unused_retire;
    assign w_unused_retire = retire_i;
    assign w_mcycle        = '0;
    assign w_minstret      = '0;
`endif

    // Vectored mode only applies to interrupts; the cause shift drops the top bit.
    assign w_base        = {r_mtvec[XLEN-1:2], 2'b00};
    assign trap_target_o = ((r_mtvec[1:0] == 2'b01) && trap_cause_i[XLEN-1])
                         ? w_base + {trap_cause_i[XLEN-3:0], 2'b00}
                         : w_base;

    assign irq_pending_o = r_mie & r_mie_csr[c_mie_mtie] & mtip_i;
    assign mepc_o        = r_mepc;
    assign mstatus_o     = w_mstatus;

endmodule

`default_nettype wire

// File: tb/tb_rv64_csr_trap_unit.sv
// ============================================================================
// Module      : tb_rv64_csr_trap_unit
// Description : Scoreboard bench for rv64_csr_trap_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv64_csr_trap_unit;

    localparam int c_sel_rdata   = 0;
    localparam int c_sel_illegal = 1;
    localparam int c_sel_irq     = 2;
    localparam int c_sel_target  = 3;
    localparam int c_sel_mepc    = 4;
    localparam int c_sel_mstatus = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [63:0] csr_wdata_i;
    logic [63:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        trap_valid_i;
    logic [63:0] trap_cause_i;
    logic [63:0] trap_pc_i;
    logic [63:0] trap_tval_i;
    logic        mret_i;
    logic        retire_i;
    logic        mtip_i;
    logic        irq_pending_o;
    logic [63:0] trap_target_o;
    logic [63:0] mepc_o;
    logic [63:0] mstatus_o;

    always #5 clk = ~clk;

    rv64_csr_trap_unit dut (
        .clk           (clk),
        .rst           (rst),
        .csr_addr_i    (csr_addr_i),
        .csr_op_i      (csr_op_i),
        .csr_wdata_i   (csr_wdata_i),
        .csr_rdata_o   (csr_rdata_o),
        .csr_illegal_o (csr_illegal_o),
        .trap_valid_i  (trap_valid_i),
        .trap_cause_i  (trap_cause_i),
        .trap_pc_i     (trap_pc_i),
        .trap_tval_i   (trap_tval_i),
        .mret_i        (mret_i),
        .retire_i      (retire_i),
        .mtip_i        (mtip_i),
        .irq_pending_o (irq_pending_o),
        .trap_target_o (trap_target_o),
        .mepc_o        (mepc_o),
        .mstatus_o     (mstatus_o)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    exp_t        m_e;
    logic [63:0] m_act;

    // Monitor: everything queued during a cycle is compared on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            case (m_e.sel)
                c_sel_rdata:   m_act = csr_rdata_o;
                c_sel_illegal: m_act = {63'b0, csr_illegal_o};
                c_sel_irq:     m_act = {63'b0, irq_pending_o};
                c_sel_target:  m_act = trap_target_o;
                c_sel_mepc:    m_act = mepc_o;
                default:       m_act = mstatus_o;
            endcase
            checks++;
            if (m_act !== m_e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", m_e.name, m_act, m_e.exp);
            end
        end
    end

    task automatic exp_push(input string name, input int sel, input logic [63:0] v);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        trap_valid_i = 1'b0;
        mret_i       = 1'b0;
        retire_i     = 1'b0;
        csr_op_i     = 2'b00;
        csr_wdata_i  = '0;
        csr_addr_i   = '0;
    endtask

    task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [63:0] d);
        csr_addr_i  = a;
        csr_op_i    = op;
        csr_wdata_i = d;
    endtask

    task automatic trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] tval);
        trap_valid_i = 1'b1;
        trap_cause_i = cause;
        trap_pc_i    = pc;
        trap_tval_i  = tval;
    endtask

    initial begin
        rst = 1'b1;
        mtip_i = 1'b0;
        trap_cause_i = '0;
        trap_pc_i = '0;
        trap_tval_i = '0;
        trap_valid_i = 1'b0;
        mret_i = 1'b0;
        retire_i = 1'b0;
        csr(12'h000, 2'b00, 64'h0);
        repeat (3) cyc();
        rst = 1'b0;

        // Reset state
        csr(12'h300, 2'b00, 64'h0);
        exp_push("rst_mstatus_rd", c_sel_rdata, 64'h0000000a00001800);
        exp_push("rst_mstatus_o", c_sel_mstatus, 64'h0000000a00001800);
        exp_push("rst_irq", c_sel_irq, 64'h0);
        exp_push("rst_mepc", c_sel_mepc, 64'h0);
        exp_push("rst_target", c_sel_target, 64'h0);
        cyc();
        cyc();
        cyc();
        csr(12'hB00, 2'b00, 64'h0);
`ifdef CSR_COUNTERS_EN
        exp_push("mcycle_after3", c_sel_rdata, 64'h3);
`else
        exp_push("mcycle_after3", c_sel_rdata, 64'h0);
`endif
        cyc();

        // mtvec vectored redirect
        csr(12'h305, 2'b01, 64'h80000001);
        cyc();
        csr(12'h305, 2'b00, 64'h0);
        exp_push("mtvec_rd", c_sel_rdata, 64'h80000001);
        trap(64'h8000000000000007, 64'h80000000, 64'h0);
        exp_push("target_vec", c_sel_target, 64'h8000001c);
        cyc();
        trap(64'h2, 64'h80000004, 64'h0);
        exp_push("target_exc", c_sel_target, 64'h80000000);
        cyc();
        csr(12'h342, 2'b00, 64'h0);
        exp_push("mcause_rd", c_sel_rdata, 64'h2);
        exp_push("mepc_exc", c_sel_mepc, 64'h80000004);
        cyc();
        csr(12'h305, 2'b01, 64'h80000103);
        cyc();
        csr(12'h305, 2'b00, 64'h0);
        trap_cause_i = 64'h8000000000000007;
        exp_push("mtvec_mode1x", c_sel_rdata, 64'h80000100);
        exp_push("target_direct", c_sel_target, 64'h80000100);
        cyc();

        // Interrupt pending, trap entry, mret
        csr(12'h300, 2'b01, 64'h8);
        cyc();
        csr(12'h304, 2'b01, 64'h80);
        cyc();
        mtip_i = 1'b1;
        exp_push("irq_on", c_sel_irq, 64'h1);
        exp_push("mstatus_mie", c_sel_mstatus, 64'h0000000a00001808);
        cyc();
        trap(64'h8000000000000007, 64'h80000100, 64'h0);
        cyc();
        exp_push("mepc_irq", c_sel_mepc, 64'h80000100);
        exp_push("mstatus_trap", c_sel_mstatus, 64'h0000000a00001880);
        exp_push("irq_off", c_sel_irq, 64'h0);
        mret_i = 1'b1;
        cyc();
        exp_push("mstatus_mret", c_sel_mstatus, 64'h0000000a00001888);
        exp_push("irq_after_mret", c_sel_irq, 64'h1);
        mret_i = 1'b1;
        csr(12'h340, 2'b01, 64'h55);
        cyc();
        csr(12'h340, 2'b00, 64'h0);
        exp_push("mret_drops_csr", c_sel_rdata, 64'h0);
        cyc();

        // Trap beats CSR write to mepc
        trap(64'h3, 64'h80000200, 64'h77);
        csr(12'h341, 2'b01, 64'h1234);
        cyc();
        exp_push("mepc_trap_wins", c_sel_mepc, 64'h80000200);
        exp_push("mstatus_trap2", c_sel_mstatus, 64'h0000000a00001880);
        csr(12'h343, 2'b00, 64'h0);
        exp_push("mtval_rd", c_sel_rdata, 64'h77);
        cyc();
        csr(12'h341, 2'b01, 64'h1235);
        cyc();
        exp_push("mepc_bit0_csr", c_sel_mepc, 64'h1234);
        trap(64'h2, 64'h301, 64'h0);
        cyc();
        exp_push("mepc_bit0_trap", c_sel_mepc, 64'h300);
        mtip_i = 1'b0;

        // Illegal accesses and zero-operand set/clear
        csr(12'hF14, 2'b01, 64'h1);
        exp_push("ill_ro_wr", c_sel_illegal, 64'h1);
        exp_push("ill_ro_rd0", c_sel_rdata, 64'h0);
        cyc();
        mtip_i = 1'b1;
        csr(12'h344, 2'b01, 64'h80);
        exp_push("ill_mip_wr", c_sel_illegal, 64'h1);
        exp_push("ill_mip_rd0", c_sel_rdata, 64'h0);
        cyc();
        csr(12'h7C0, 2'b10, 64'h0);
        exp_push("ill_unimpl", c_sel_illegal, 64'h1);
        exp_push("ill_unimpl_rd0", c_sel_rdata, 64'h0);
        cyc();
        csr(12'h344, 2'b00, 64'h0);
        exp_push("mip_rd", c_sel_rdata, 64'h80);
        exp_push("mip_rd_legal", c_sel_illegal, 64'h0);
        cyc();
        mtip_i = 1'b0;
        csr(12'hF14, 2'b10, 64'h0);
        exp_push("ro_rs0_legal", c_sel_illegal, 64'h0);
        cyc();
        csr(12'h340, 2'b01, 64'hABC);
        cyc();
        csr(12'h340, 2'b10, 64'h0);
        exp_push("rs0_legal", c_sel_illegal, 64'h0);
        exp_push("rs0_rd", c_sel_rdata, 64'hABC);
        cyc();
        csr(12'h340, 2'b11, 64'hC);
        cyc();
        csr(12'h340, 2'b10, 64'h5);
        exp_push("rc_result", c_sel_rdata, 64'hAB0);
        cyc();
        csr(12'h340, 2'b00, 64'h0);
        exp_push("rs_result", c_sel_rdata, 64'hAB5);
        cyc();
        csr(12'h300, 2'b01, 64'hFFFFFFFFFFFFFFFF);
        cyc();
        exp_push("mstatus_wr_mask", c_sel_mstatus, 64'h0000000a00001888);
        csr(12'h300, 2'b11, 64'h80);
        cyc();
        exp_push("mstatus_rc", c_sel_mstatus, 64'h0000000a00001808);

        // Counters
`ifdef CSR_COUNTERS_EN
        csr(12'hB02, 2'b01, 64'hFFFFFFFFFFFFFFFF);
        cyc();
        retire_i = 1'b1;
        cyc();
        csr(12'hB02, 2'b00, 64'h0);
        exp_push("minstret_wrap", c_sel_rdata, 64'h0);
        cyc();
        csr(12'hB02, 2'b01, 64'h5);
        retire_i = 1'b1;
        cyc();
        csr(12'hB02, 2'b00, 64'h0);
        exp_push("minstret_load_wins", c_sel_rdata, 64'h5);
        cyc();
        csr(12'hB00, 2'b01, 64'h64);
        cyc();
        csr(12'hB00, 2'b00, 64'h0);
        exp_push("mcycle_load", c_sel_rdata, 64'h64);
        cyc();
        csr(12'hB00, 2'b00, 64'h0);
        exp_push("mcycle_inc", c_sel_rdata, 64'h65);
        cyc();
`else
        csr(12'hB02, 2'b01, 64'h5);
        retire_i = 1'b1;
        exp_push("minstret_off_legal", c_sel_illegal, 64'h0);
        cyc();
        csr(12'hB02, 2'b00, 64'h0);
        exp_push("minstret_off_rd", c_sel_rdata, 64'h0);
        cyc();
`endif

        // Reset overrides a concurrent trap and CSR write
        rst = 1'b1;
        trap(64'h5, 64'h44, 64'h9);
        csr(12'h340, 2'b01, 64'h99);
        cyc();
        rst = 1'b0;
        csr(12'h340, 2'b00, 64'h0);
        exp_push("rst_mscratch", c_sel_rdata, 64'h0);
        exp_push("rst_mepc2", c_sel_mepc, 64'h0);
        exp_push("rst_mstatus2", c_sel_mstatus, 64'h0000000a00001800);
        cyc();

        for (int i = 0; i < 5 && sb.size() > 0; i++) cyc();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
